// File: rtl/startup_pkg.sv
// Shared types and constants for the TX data-link startup handshake.
package startup_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND   = 3'd1,
    S_LISTEN = 3'd2,
    S_DONE   = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam int         DUTY_W          = 7;
  localparam logic [3:0] RESP_PATTERN    = 4'b1111;
  localparam int         PREAMBLE_PHASES = 8;

  // Sum is formed in 8 bits so a 7-bit duty near the top never wraps before the clamp.
  function automatic logic [DUTY_W-1:0] duty_inc(input logic [DUTY_W-1:0] d,
                                                 input int step, input int max);
    logic [7:0] s;
    s = {1'b0, d} + 8'(step);
    return (s > 8'(max)) ? DUTY_W'(max) : s[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/startup_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module startup_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!nrst)             cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/startup_handshake_ctrl.sv
// Startup handshake sequencer: 1111 preamble, RX response window, duty ramp on retry.
// Optional retry limit / FAIL state enabled by defining STARTUP_RETRY_LIMIT_EN.
module startup_handshake_ctrl
  import startup_pkg::*;
#(
  parameter int HALF_CYCLES = 100000,
  parameter int WAIT_CYCLES = 250000,
  parameter int DUTY_INIT   = 50,
  parameter int DUTY_STEP   = 5,
  parameter int DUTY_MAX    = 95,
  parameter int MAX_RETRIES = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              data_start,
  input  logic              rx_valid,
  input  logic              rx_bit,
  output logic              tx_d,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              startup_compl,
  output logic              startup_fail
);

  localparam int TMAX = (HALF_CYCLES > WAIT_CYCLES) ? HALF_CYCLES : WAIT_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] HALF_LD   = TW'(HALF_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LD   = TW'(WAIT_CYCLES - 1);
  localparam logic [2:0]    LAST_PHASE = 3'(PREAMBLE_PHASES - 1);

  if (DUTY_INIT > DUTY_MAX || MAX_RETRIES < 1) begin : g_cfg_err
    $error("startup_handshake_ctrl: DUTY_INIT exceeds DUTY_MAX or MAX_RETRIES < 1");
  end

  state_t        state;
  logic [2:0]    phase;
  logic [3:0]    rx_sh;
  logic [3:0]    sh_next;
  logic          match;
  logic          at_limit;
  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_done;

`ifdef STARTUP_RETRY_LIMIT_EN
  localparam int RW = $clog2(MAX_RETRIES + 1);
  logic [RW-1:0] retry;
  assign at_limit = (retry == RW'(MAX_RETRIES - 1));
`else
  assign at_limit     = 1'b0;
  assign startup_fail = 1'b0;
`endif

  startup_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .nrst     (nrst),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  // Match is judged on the shift value including this cycle's bit, so it beats a coincident expiry.
  always_comb begin
    sh_next = rx_valid ? {rx_sh[2:0], rx_bit} : rx_sh;
    match   = (state == S_LISTEN) && (sh_next == RESP_PATTERN);
    t_load  = 1'b0;
    t_val   = '0;
    case (state)
      S_IDLE: begin
        t_load = 1'b1;
        t_val  = data_start ? HALF_LD : '0;
      end
      S_SEND: begin
        if (!data_start) t_load = 1'b1;
        else if (t_done) begin
          t_load = 1'b1;
          t_val  = (phase == LAST_PHASE) ? WAIT_LD : HALF_LD;
        end
      end
      S_LISTEN: begin
        if (!data_start || match) t_load = 1'b1;
        else if (t_done) begin
          t_load = 1'b1;
          t_val  = at_limit ? '0 : HALF_LD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state         <= S_IDLE;
      phase         <= '0;
      rx_sh         <= '0;
      tx_d          <= 1'b0;
      duty          <= DUTY_W'(DUTY_INIT);
      busy          <= 1'b0;
      startup_compl <= 1'b0;
`ifdef STARTUP_RETRY_LIMIT_EN
      startup_fail  <= 1'b0;
      retry         <= '0;
`endif
    end else if ((state == S_SEND || state == S_LISTEN) && !data_start) begin
      // Abort keeps the duty ramp so the next attempt resumes at the raised setpoint.
      state <= S_IDLE;
      phase <= '0;
      rx_sh <= '0;
      tx_d  <= 1'b0;
      busy  <= 1'b0;
`ifdef STARTUP_RETRY_LIMIT_EN
      retry <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          tx_d <= 1'b0;
          if (data_start) begin
            state <= S_SEND;
            phase <= '0;
            busy  <= 1'b1;
          end
        end
        S_SEND: begin
          if (t_done) begin
            if (phase == LAST_PHASE) begin
              state <= S_LISTEN;
              phase <= '0;
              rx_sh <= '0;
              tx_d  <= 1'b0;
            end else begin
              phase <= phase + 1'b1;
              tx_d  <= ~phase[0];
            end
          end
        end
        S_LISTEN: begin
          rx_sh <= sh_next;
          if (match) begin
            state         <= S_DONE;
            startup_compl <= 1'b1;
            busy          <= 1'b0;
            tx_d          <= 1'b0;
          end else if (t_done) begin
            duty <= duty_inc(duty, DUTY_STEP, DUTY_MAX);
`ifdef STARTUP_RETRY_LIMIT_EN
            retry <= retry + 1'b1;
            if (at_limit) begin
              state        <= S_FAIL;
              startup_fail <= 1'b1;
              busy         <= 1'b0;
            end else
`endif
            begin
              state <= S_SEND;
              phase <= '0;
              tx_d  <= 1'b0;
            end
          end
        end
        S_DONE: ;
`ifdef STARTUP_RETRY_LIMIT_EN
        S_FAIL: ;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
